adder_error_monitor: RTL and testbench
======================================

// Module: adder_error_monitor
// PURPOSE
//  Downstream consumer of a 16b approximate adder (e.g. pruned Kogge-Stone) under test.
//  Takes operand pairs plus the approximate sum, computes the exact sum internally, and
//  accumulates error metrics over a programmed run of N samples.
//  Metrics: error count, summed error distance, max error distance.
//  Replaces offline post-processing of the sum dump with on-chip reporting.
// PARAMETERS
//  W      16  operand width; approximate sum is W+1 bits
//  CNT_W  20  sample-counter width (runs up to 2^CNT_W-1 samples; 500000 fits)
// PORTS
//  clk         in   1            rising-edge clock
//  rst_n       in   1            synchronous, active-low reset
//  start       in   1            pulse: begin run (accepted in IDLE or DONE only)
//  n_samples   in   CNT_W        run length; sampled on accepted start
//  in_valid    in   1            operand/sum beat valid
//  in_ready    out  1            monitor can accept a beat
//  op_a        in   W            operand A
//  op_b        in   W            operand B
//  approx_s    in   W+1          approximate adder output for (op_a, op_b)
//  busy        out  1            run in progress
//  done        out  1            results valid; held until next start or reset
//  err_count   out  CNT_W        beats with approx_s != op_a+op_b
//  ed_sum      out  W+1+CNT_W    sum of |exact - approx_s|; cannot overflow
//  ed_max      out  W+1          largest error distance in the run
//  sample_cnt  out  CNT_W        beats retired in the run
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): FSM=IDLE; all outputs 0; pipeline valids cleared.
//    Applies mid-run as well; partial results are discarded.
//  FSM states and transitions:
//    IDLE  -> RUN   on start
//    RUN   -> DRAIN after the n-th accept
//    DRAIN -> DONE  when pipeline is empty
//    DONE  -> RUN   on start
//  start with n_samples=0: RUN->DONE next cycle, all metrics 0, no beat accepted.
//  start in RUN or DRAIN: ignored.
//  Entering RUN: accumulators, counters and done clear in the same cycle.
//  in_ready = (state==RUN) && (accepted < n_samples). Registered; low in IDLE, DRAIN and DONE.
//  Transfer occurs when in_valid && in_ready. Gaps in in_valid are allowed.
//  Pipeline, one beat/cycle:
//    S1 registers exact = op_a+op_b (W+1 bits) and approx_s.
//    S2 registers ed = |exact-approx_s| and err = (ed!=0).
//    Accumulate stage updates ed_sum += ed, ed_max = max(ed_max, ed), err_count += err,
//    sample_cnt += 1.
//    Latency accept -> metrics updated: 3 cycles.
//  done rises the cycle after the last beat accumulates (FSM DONE).
//  busy = (state==RUN || state==DRAIN).
//  ed is unsigned magnitude. Max possible ed = 2^(W+1)-1.
//  ed_sum width guarantees no wrap for any legal n_samples.
// CONFIGURATION
//  Macro ADDER_ERR_MSE_EN:
//    Defined: adds output ed_sq_sum [2*(W+1)+CNT_W-1:0] = sum of ed*ed.
//      The squaring is registered in S2, so latency is unchanged.
//      Reset and start clearing match ed_sum.
//    Undefined: port and multiplier absent; all other behaviour identical.
// STRUCTURE
//  Package adder_err_pkg holds:
//    state enum (IDLE, RUN, DRAIN, DONE)
//    default W/CNT_W localparams
//    ed-width helper constants
//  Sub-module abs_diff #(N): combinational |x-y| for N-bit unsigned values.
//    Instanced in S2; unit-testable alone.
//  Remaining logic (FSM, counters, accumulators) stays flat in this module.
// TESTING
//  Exact beats, n=4: (3,5,8), (0,0,0), (FFFF,1,10000), (8000,8000,10000)
//    -> err_count=0, ed_sum=0, ed_max=0, sample_cnt=4, done=1.
//  Dropped carry, n=1: a=FFFF, b=0001, approx_s=0
//    -> ed_max=10000h, ed_sum=10000h, err_count=1.
//  n=3 with in_valid gaps (1-0-1-0-1); eds 1,2,3 -> ed_sum=6, ed_max=3, err_count=3.
//    in_ready must fall after the 3rd accept.
//  start with n_samples=0 -> done=1 one cycle later; all metrics 0; in_ready never high.
//  rst_n=0 for one cycle mid-run after 2 of 5 beats
//    -> next cycle all outputs 0, FSM IDLE, in_ready=0.
//    A subsequent start runs cleanly.
//  With ADDER_ERR_MSE_EN, eds 1,2,3 -> ed_sq_sum=14.
//    Without the macro, the port is absent and the design elaborates.

Source files
------------

// File: rtl/adder_error_monitor_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// The optional squared-error output is enabled by defining ADDER_ERR_MSE_EN.
package adder_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_W     = 16;
    localparam int DEF_CNT_W = 20;

    // Error distance carries one more bit than the operands (the carry-out).
    function automatic int edWidth(input int w);
        return w + 1;
    endfunction

    function automatic int edSumWidth(input int w, input int cntW);
        return w + 1 + cntW;
    endfunction

    function automatic int edSqSumWidth(input int w, input int cntW);
        return 2 * (w + 1) + cntW;
    endfunction

endpackage

// File: rtl/adder_error_monitor_abs_diff.sv
// Combinational unsigned magnitude difference |x - y| for N-bit operands.
module abs_diff #(
    parameter int N = 17
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff
);

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        diff = {N{1'b0}};
        if (x >= y) begin
            diff = x - y;
        end else begin
            diff = y - x;
        end
    end

endmodule

// File: rtl/adder_error_monitor.sv
// On-chip error metrics (count, summed and max distance) for a W-bit approximate adder.
// Define ADDER_ERR_MSE_EN to add the ed_sq_sum (sum of squared distances) output.
module adder_error_monitor
    import adder_err_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [CNT_W-1:0]                   n_samples,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [W-1:0]                       op_a,
    input  logic [W-1:0]                       op_b,
    input  logic [W:0]                         approx_s,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_W-1:0]                   err_count,
    output logic [edSumWidth(W, CNT_W)-1:0]    ed_sum,
    output logic [W:0]                         ed_max,
    output logic [CNT_W-1:0]                   sample_cnt
`ifdef ADDER_ERR_MSE_EN
    ,
    output logic [edSqSumWidth(W, CNT_W)-1:0]  ed_sq_sum
`endif
);

    localparam int ED_W     = edWidth(W);
    localparam int ED_SUM_W = edSumWidth(W, CNT_W);

    state_t           state_r, nextState_s;
    logic [CNT_W-1:0] nTarget_r, nTargetNext_s;
    logic [CNT_W-1:0] acceptCnt_r, acceptNext_s;
    logic             accept_s, lastAccept_s, startRun_s, pipeEmpty_s, inReadyNext_s;

    logic             s1Valid_r, s2Valid_r;
    logic [ED_W-1:0]  exact_r, approx_r;
    logic [ED_W-1:0]  edComb_s, ed_r;
    logic             err_r;

`ifdef ADDER_ERR_MSE_EN
    localparam int SQ_W     = 2 * ED_W;
    localparam int SQ_SUM_W = edSqSumWidth(W, CNT_W);
    logic [SQ_W-1:0]  edSq_r;
`endif

    assign accept_s     = in_valid && in_ready;
    assign lastAccept_s = accept_s && (acceptCnt_r == (nTarget_r - CNT_W'(1)));
    assign startRun_s   = start && ((state_r == IDLE) || (state_r == DONE));
    assign pipeEmpty_s  = !s1Valid_r && !s2Valid_r;

    // Next-state, run-length and accept-count logic; in_ready is precomputed for registering.
    always_comb begin
        nextState_s   = state_r;
        nTargetNext_s = nTarget_r;
        acceptNext_s  = acceptCnt_r;
        case (state_r)
            IDLE: begin
                if (startRun_s) nextState_s = RUN;
                else            nextState_s = IDLE;
            end
            RUN: begin
                if (nTarget_r == {CNT_W{1'b0}}) nextState_s = DONE;
                else if (lastAccept_s)          nextState_s = DRAIN;
                else                            nextState_s = RUN;
            end
            DRAIN: begin
                if (pipeEmpty_s) nextState_s = DONE;
                else             nextState_s = DRAIN;
            end
            DONE: begin
                if (startRun_s) nextState_s = RUN;
                else            nextState_s = DONE;
            end
            default: nextState_s = IDLE;
        endcase
        if (startRun_s) begin
            nTargetNext_s = n_samples;
            acceptNext_s  = {CNT_W{1'b0}};
        end else if (accept_s) begin
            acceptNext_s  = acceptCnt_r + CNT_W'(1);
        end else begin
            acceptNext_s  = acceptCnt_r;
        end
        inReadyNext_s = (nextState_s == RUN) && (acceptNext_s < nTargetNext_s);
    end

    // FSM state, run bookkeeping and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            nTarget_r   <= {CNT_W{1'b0}};
            acceptCnt_r <= {CNT_W{1'b0}};
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= nextState_s;
            nTarget_r   <= nTargetNext_s;
            acceptCnt_r <= acceptNext_s;
            in_ready    <= inReadyNext_s;
            busy        <= (nextState_s == RUN) || (nextState_s == DRAIN);
            done        <= (nextState_s == DONE);
        end
    end

    abs_diff #(.N(ED_W)) u_absDiff (
        .x    (exact_r),
        .y    (approx_r),
        .diff (edComb_s)
    );

    // Two-stage datapath: S1 exact sum, S2 error distance (and its square).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_r <= 1'b0;
            s2Valid_r <= 1'b0;
            exact_r   <= {ED_W{1'b0}};
            approx_r  <= {ED_W{1'b0}};
            ed_r      <= {ED_W{1'b0}};
            err_r     <= 1'b0;
`ifdef ADDER_ERR_MSE_EN
            edSq_r    <= {SQ_W{1'b0}};
`endif
        end else begin
            s1Valid_r <= accept_s;
            s2Valid_r <= s1Valid_r;
            if (accept_s) begin
                exact_r  <= {1'b0, op_a} + {1'b0, op_b};
                approx_r <= approx_s;
            end
            if (s1Valid_r) begin
                ed_r   <= edComb_s;
                err_r  <= (edComb_s != {ED_W{1'b0}});
`ifdef ADDER_ERR_MSE_EN
                edSq_r <= SQ_W'(edComb_s) * SQ_W'(edComb_s);
`endif
            end
        end
    end

    // Metric accumulators; cleared on reset and on every accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n || startRun_s) begin
            err_count  <= {CNT_W{1'b0}};
            ed_sum     <= {ED_SUM_W{1'b0}};
            ed_max     <= {ED_W{1'b0}};
            sample_cnt <= {CNT_W{1'b0}};
`ifdef ADDER_ERR_MSE_EN
            ed_sq_sum  <= {SQ_SUM_W{1'b0}};
`endif
        end else if (s2Valid_r) begin
            err_count  <= err_count + CNT_W'(err_r);
            ed_sum     <= ed_sum + ED_SUM_W'(ed_r);
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (ed_r > ed_max) ed_max <= ed_r;
`ifdef ADDER_ERR_MSE_EN
            ed_sq_sum  <= ed_sq_sum + SQ_SUM_W'(edSq_r);
`endif
        end
    end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed self-checking bench for adder_error_monitor (W=16, CNT_W=20).
// Also checks ed_sq_sum when built with ADDER_ERR_MSE_EN.
module tb_adder_error_monitor;

    localparam int W     = 16;
    localparam int CNT_W = 20;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [CNT_W-1:0]       n_samples = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [W-1:0]           op_a = '0;
    logic [W-1:0]           op_b = '0;
    logic [W:0]             approx_s = '0;
    logic                   busy, done;
    logic [CNT_W-1:0]       err_count, sample_cnt;
    logic [W+CNT_W:0]       ed_sum;
    logic [W:0]             ed_max;
`ifdef ADDER_ERR_MSE_EN
    logic [2*(W+1)+CNT_W-1:0] ed_sq_sum;
`endif

    int total = 0;
    int bad   = 0;

    adder_error_monitor #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_samples  (n_samples),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .approx_s   (approx_s),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .ed_sum     (ed_sum),
        .ed_max     (ed_max),
        .sample_cnt (sample_cnt)
`ifdef ADDER_ERR_MSE_EN
        ,
        .ed_sq_sum  (ed_sq_sum)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkMetrics(input string tag, input logic [63:0] ec, input logic [63:0] es,
                                input logic [63:0] em, input logic [63:0] sc);
        check({tag, "_err_count"},  64'(err_count),  ec);
        check({tag, "_ed_sum"},     64'(ed_sum),     es);
        check({tag, "_ed_max"},     64'(ed_max),     em);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), sc);
    endtask

    task automatic checkIdleZero(input string tag);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        checkMetrics(tag, 64'd0, 64'd0, 64'd0, 64'd0);
`ifdef ADDER_ERR_MSE_EN
        check({tag, "_ed_sq_sum"}, 64'(ed_sq_sum), 64'd0);
`endif
    endtask

    task automatic startRun(input logic [CNT_W-1:0] n);
        start = 1'b1;
        n_samples = n;
        step();
        start = 1'b0;
        n_samples = 20'hABCDE;   // must be ignored once the run is started
    endtask

    task automatic sendBeat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s);
        int k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check("ready_wait", 64'(in_ready), 64'd1);
        op_a = a;
        op_b = b;
        approx_s = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic waitDone();
        int k = 0;
        while (!done && k < 30) begin
            step();
            k++;
        end
        check("done_wait", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        checkIdleZero("reset");
        rst_n = 1'b1;
        step();
        checkIdleZero("post_reset");

        // Exact beats, n=4
        startRun(20'd4);
        check("t1_busy",  64'(busy),     64'd1);
        check("t1_ready", 64'(in_ready), 64'd1);
        check("t1_done",  64'(done),     64'd0);
        sendBeat(16'h0003, 16'h0005, 17'h00008);
        sendBeat(16'h0000, 16'h0000, 17'h00000);
        sendBeat(16'hFFFF, 16'h0001, 17'h10000);
        sendBeat(16'h8000, 16'h8000, 17'h10000);
        check("t1_ready_fall", 64'(in_ready), 64'd0);
        waitDone();
        checkMetrics("t1", 64'd0, 64'd0, 64'd0, 64'd4);

        // Dropped carry, n=1, with exact latency checks
        startRun(20'd1);
        sendBeat(16'hFFFF, 16'h0001, 17'h00000);
        check("t2_lat0", 64'(sample_cnt), 64'd0);
        step();
        check("t2_lat1", 64'(sample_cnt), 64'd0);
        step();
        check("t2_lat2", 64'(sample_cnt), 64'd1);
        check("t2_lat2_done", 64'(done), 64'd0);
        step();
        check("t2_done", 64'(done), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);
        checkMetrics("t2", 64'd1, 64'h10000, 64'h10000, 64'd1);

        // n=3 with gaps, eds 1,2,3
        startRun(20'd3);
        sendBeat(16'd1, 16'd1, 17'd3);
        step();
        sendBeat(16'd2, 16'd2, 17'd2);
        check("t3_ready_mid", 64'(in_ready), 64'd1);
        step();
        sendBeat(16'd4, 16'd4, 17'd5);
        check("t3_ready_fall", 64'(in_ready), 64'd0);
        waitDone();
        checkMetrics("t3", 64'd3, 64'd6, 64'd3, 64'd3);
`ifdef ADDER_ERR_MSE_EN
        check("t3_ed_sq_sum", 64'(ed_sq_sum), 64'd14);
`endif

        // start with n_samples=0
        startRun(20'd0);
        check("t4_busy",  64'(busy),     64'd1);
        check("t4_ready", 64'(in_ready), 64'd0);
        check("t4_done_clr", 64'(done),  64'd0);
        checkMetrics("t4_clr", 64'd0, 64'd0, 64'd0, 64'd0);
        step();
        check("t4_done",   64'(done),     64'd1);
        check("t4_busy2",  64'(busy),     64'd0);
        check("t4_ready2", 64'(in_ready), 64'd0);
        checkMetrics("t4", 64'd0, 64'd0, 64'd0, 64'd0);

        // Mid-run reset after 2 of 5 beats; start during RUN is ignored
        startRun(20'd5);
        sendBeat(16'd10, 16'd10, 17'd21);
        sendBeat(16'd10, 16'd10, 17'd19);
        start = 1'b1;
        n_samples = 20'd1;
        step();
        start = 1'b0;
        step();
        step();
        check("t5_pre_cnt",   64'(sample_cnt), 64'd2);
        check("t5_pre_ready", 64'(in_ready),   64'd1);
        check("t5_pre_sum",   64'(ed_sum),     64'd2);
        rst_n = 1'b0;
        step();
        checkIdleZero("t5_reset");
        rst_n = 1'b1;
        step();
        checkIdleZero("t5_idle");

        // Clean run after reset: one exact beat, one with ed=2
        startRun(20'd2);
        checkMetrics("t6_clr", 64'd0, 64'd0, 64'd0, 64'd0);
        sendBeat(16'd10, 16'd20, 17'd30);
        sendBeat(16'd7, 16'd0, 17'd5);
        waitDone();
        checkMetrics("t6", 64'd1, 64'd2, 64'd2, 64'd2);
`ifdef ADDER_ERR_MSE_EN
        check("t6_ed_sq_sum", 64'(ed_sq_sum), 64'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
